// File: rtl/sdram_xfer_sequencer.sv
// Drives the user side of the softproc SDRAM write/read master templates, turning
// word-count commands into byte-addressed go/done handshakes and FIFO push/pop traffic.
//
// state  | meaning
// SYNC   | wait for both masters to report done (reset may land mid-transfer)
// IDLE   | accept or reject cmd_write / cmd_read
// W_GO   | one-cycle wm_go
// W_DATA | push capture words into the write-master FIFO
// W_WAIT | wait for wm_done once the guard expires
// R_GO   | one-cycle rm_go
// R_DATA | pop read-master FIFO words to the readback port
// R_WAIT | wait for rm_done once the guard expires
// DONE   | one-cycle cmd_done
module sdram_xfer_sequencer #(
  parameter int MAX_WORDS = 65535
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cmd_write,
  input  logic        cmd_read,
  input  logic [31:0] cmd_base,
  input  logic [15:0] cmd_words,
  output logic        busy,
  output logic        cmd_done,
  output logic        cmd_err,
  input  logic        cap_valid,
  input  logic [31:0] cap_data,
  output logic        cap_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        wm_fixed_location,
  output logic        wm_go,
  output logic        wm_write_buffer,
  output logic [31:0] wm_write_base,
  output logic [31:0] wm_write_length,
  output logic [31:0] wm_buffer_input_data,
  input  logic        wm_done,
  input  logic        wm_buffer_full,
  output logic        rm_fixed_location,
  output logic        rm_go,
  output logic        rm_read_buffer,
  output logic [31:0] rm_read_base,
  output logic [31:0] rm_read_length,
  input  logic        rm_done,
  input  logic        rm_early_done,
  input  logic        rm_data_available,
  input  logic [31:0] rm_buffer_output_data
);

  typedef enum logic [3:0] {
    SYNC, IDLE, W_GO, W_DATA, W_WAIT, R_GO, R_DATA, R_WAIT, DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_base;
  logic [31:0] r_len;
  logic [15:0] r_remaining;
  logic [1:0]  r_guard;
  logic        r_cmd_err;

  logic w_rem_nz;
  logic w_cmd_bad;
  logic w_wr_hs;
  logic w_rd_hs;
  logic w_unused;

  assign w_unused  = rm_early_done;
  assign w_rem_nz  = (r_remaining != 16'd0);
  assign w_cmd_bad = (cmd_words == 16'd0) ||
                     ({16'd0, cmd_words} > MAX_WORDS[31:0]) ||
                     (cmd_base[1:0] != 2'b00);

  assign cap_ready            = (r_state == W_DATA) && !wm_buffer_full && w_rem_nz;
  assign w_wr_hs              = cap_valid && cap_ready;
  assign wm_write_buffer      = w_wr_hs;
  assign wm_buffer_input_data = cap_data;

  assign out_valid      = (r_state == R_DATA) && rm_data_available && w_rem_nz;
  assign out_data       = rm_buffer_output_data;
  assign w_rd_hs        = out_valid && out_ready;
  assign rm_read_buffer = w_rd_hs;

  assign wm_go    = (r_state == W_GO);
  assign rm_go    = (r_state == R_GO);
  assign cmd_done = (r_state == DONE);
  assign busy     = (r_state != IDLE);
  assign cmd_err  = r_cmd_err;

  assign wm_fixed_location = 1'b0;
  assign rm_fixed_location = 1'b0;
  assign wm_write_base     = r_base;
  assign wm_write_length   = r_len;
  assign rm_read_base      = r_base;
  assign rm_read_length    = r_len;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= SYNC;
      r_base      <= 32'd0;
      r_len       <= 32'd0;
      r_remaining <= 16'd0;
      r_guard     <= 2'd0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      if (r_guard != 2'd0) r_guard <= r_guard - 2'd1;
      case (r_state)
        SYNC: if (wm_done && rm_done) r_state <= IDLE;
        IDLE: begin
          if (cmd_write || cmd_read) begin
            if (w_cmd_bad) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_base      <= cmd_base;
              r_len       <= {14'b0, cmd_words, 2'b00};
              r_remaining <= cmd_words;
              r_state     <= cmd_write ? W_GO : R_GO;
            end
          end
        end
        // Masters drop done one cycle after go; the guard hides the stale high.
        W_GO: begin
          r_guard <= 2'd2;
          r_state <= W_DATA;
        end
        W_DATA: begin
          if (w_wr_hs) r_remaining <= r_remaining - 16'd1;
          if (!w_rem_nz || (w_wr_hs && r_remaining == 16'd1)) r_state <= W_WAIT;
        end
        W_WAIT: if (r_guard == 2'd0 && wm_done) r_state <= DONE;
        R_GO: begin
          r_guard <= 2'd2;
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (w_rd_hs) r_remaining <= r_remaining - 16'd1;
          if (!w_rem_nz || (w_rd_hs && r_remaining == 16'd1)) r_state <= R_WAIT;
        end
        R_WAIT: if (r_guard == 2'd0 && rm_done) r_state <= DONE;
        DONE:   r_state <= IDLE;
        default: r_state <= SYNC;
      endcase
    end
  end

endmodule
